// File: rtl/stream_mux_rr.sv
// stream_mux_rr: selects one of CHANNELS valid/ready streams, by external sel or round-robin, into a one-entry output register.
// Latency: a word accepted at edge N is presented with out_valid=1 from cycle N+1; sustains one word per cycle.
// Backpressure: while a held word sees out_ready=0, the register freezes and every in_ready stays low.
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready are the per-channel input streams
//        (channel i at in_data[i*WIDTH +: WIDTH]); sel picks the channel when RR=0;
//        out_data/out_chan/out_valid/out_ready form the registered output stream.
module stream_mux_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int RR       = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int               NSEL    = 1 << SEL_W;
  localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [NSEL-1:0]  valid_ext;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   rr_sum;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Valid vector widened to the full select range; the padding bits are zero,
  // so any select value at or above CHANNELS can never produce a grant.
  assign valid_ext = NSEL'(in_valid);

  // The register can take a new word when it is empty or its word leaves this cycle.
  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_valid;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_sum      = '0;
    rr_idx      = '0;
    if (RR == 0) begin
      grant       = sel;
      grant_valid = valid_ext[sel];
    end else begin
      // Walk the search order from its far end back to rr_ptr, so the last
      // hit recorded is the valid channel closest to rr_ptr.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (rr_sum >= CH_CNT) begin
          rr_sum = rr_sum - CH_CNT;
        end
        rr_idx = rr_sum[SEL_W-1:0];
        if (valid_ext[rr_idx]) begin
          grant       = rr_idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is driven only toward the granted channel, and never during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && xfer && (grant == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
        if (RR != 0) begin
          rr_ptr <= (grant == LAST_CH) ? '0 : grant + SEL_W'(1);
        end
      end else begin
        // Nothing to load: drain, keeping the last data/channel visible.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n;

  // Stimulus set A: WIDTH=4, CHANNELS=4 (u0 external select, u1 round-robin)
  logic [15:0] a_data;
  logic [3:0]  a_valid;
  logic [1:0]  a_sel;
  logic        a_ordy;
  logic [3:0]  r0_irdy, r1_irdy;
  logic [3:0]  r0_data, r1_data;
  logic [1:0]  r0_chan, r1_chan;
  logic        r0_ovld, r1_ovld;

  // Stimulus set B: WIDTH=8, CHANNELS=3 (u2 external select, u3 round-robin)
  logic [23:0] b_data;
  logic [2:0]  b_valid;
  logic [1:0]  b_sel;
  logic        b_ordy;
  logic [2:0]  s0_irdy, s1_irdy;
  logic [7:0]  s0_data, s1_data;
  logic [1:0]  s0_chan, s1_chan;
  logic        s0_ovld, s1_ovld;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .RR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(r0_irdy),
    .sel(a_sel), .out_data(r0_data), .out_chan(r0_chan), .out_valid(r0_ovld), .out_ready(a_ordy));

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .RR(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(r1_irdy),
    .sel(a_sel), .out_data(r1_data), .out_chan(r1_chan), .out_valid(r1_ovld), .out_ready(a_ordy));

  stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .RR(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(s0_irdy),
    .sel(b_sel), .out_data(s0_data), .out_chan(s0_chan), .out_valid(s0_ovld), .out_ready(b_ordy));

  stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .RR(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(s1_irdy),
    .sel(b_sel), .out_data(s1_data), .out_chan(s1_chan), .out_valid(s1_ovld), .out_ready(b_ordy));

  // Advance past the next rising edge to the input drive point.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    a_data = '0; a_valid = '0; a_sel = '0; a_ordy = 1'b0;
    b_data = '0; b_valid = '0; b_sel = '0; b_ordy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (r1_ovld !== 1'b0) begin miscompares++; $display("FAIL reset_ovld got=%0b exp=0", r1_ovld); end
    vectors++; if (r1_data !== 4'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", r1_data); end
    vectors++; if (r1_chan !== 2'd0) begin miscompares++; $display("FAIL reset_chan got=%0d exp=0", r1_chan); end
    @(negedge clk);
    rst_n = 1'b1;
    step;
    a_valid = 4'hF; a_data = 16'h4321; a_ordy = 1'b1; a_sel = 2'd0;
    step;
    step;
    vectors++; if (r1_chan !== 2'd1) begin miscompares++; $display("FAIL pre_reset_chan got=%0d exp=1", r1_chan); end
    vectors++; if (r1_data !== 4'h2) begin miscompares++; $display("FAIL pre_reset_data got=%h exp=2", r1_data); end
    // Mid-stream reset between edges: outputs clear without waiting for a clock.
    rst_n = 1'b0;
    #1;
    vectors++; if (r1_ovld !== 1'b0) begin miscompares++; $display("FAIL midrst_ovld got=%0b exp=0", r1_ovld); end
    vectors++; if (r1_data !== 4'h0) begin miscompares++; $display("FAIL midrst_data got=%h exp=0", r1_data); end
    vectors++; if (r1_chan !== 2'd0) begin miscompares++; $display("FAIL midrst_chan got=%0d exp=0", r1_chan); end
    vectors++; if (r1_irdy !== 4'h0) begin miscompares++; $display("FAIL midrst_irdy_rr got=%b exp=0000", r1_irdy); end
    vectors++; if (r0_irdy !== 4'h0) begin miscompares++; $display("FAIL midrst_irdy_sel got=%b exp=0000", r0_irdy); end
    #1 rst_n = 1'b1;
    step;
    vectors++; if (r1_ovld !== 1'b1) begin miscompares++; $display("FAIL post_rst_ovld got=%0b exp=1", r1_ovld); end
    vectors++; if (r1_chan !== 2'd0) begin miscompares++; $display("FAIL post_rst_chan got=%0d exp=0", r1_chan); end
    vectors++; if (r1_data !== 4'h1) begin miscompares++; $display("FAIL post_rst_data got=%h exp=1", r1_data); end
  endtask

  task automatic test_stall;
    a_valid = '0; a_ordy = 1'b1;
    step;
    a_sel = 2'd2; a_valid = 4'b0100; a_data = 16'h0A00; a_ordy = 1'b0;
    @(negedge clk);
    vectors++; if (r0_irdy !== 4'b0100) begin miscompares++; $display("FAIL stall_accept_irdy got=%b exp=0100", r0_irdy); end
    step;
    a_data = 16'h0500;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a_sel = 2'($urandom_range(0, 3));
        a_valid = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      vectors++; if (r0_ovld !== 1'b1) begin miscompares++; $display("FAIL stall_ovld[%0d] got=%0b exp=1", i, r0_ovld); end
      vectors++; if (r0_data !== 4'hA) begin miscompares++; $display("FAIL stall_data[%0d] got=%h exp=a", i, r0_data); end
      vectors++; if (r0_chan !== 2'd2) begin miscompares++; $display("FAIL stall_chan[%0d] got=%0d exp=2", i, r0_chan); end
      vectors++; if (r0_irdy !== 4'h0) begin miscompares++; $display("FAIL stall_irdy[%0d] got=%b exp=0000", i, r0_irdy); end
      step;
    end
    a_sel = 2'd2; a_valid = 4'b0100; a_ordy = 1'b1;
    @(negedge clk);
    vectors++; if (r0_irdy !== 4'b0100) begin miscompares++; $display("FAIL release_irdy got=%b exp=0100", r0_irdy); end
    step;
    vectors++; if (r0_data !== 4'h5) begin miscompares++; $display("FAIL release_data got=%h exp=5", r0_data); end
    vectors++; if (r0_chan !== 2'd2) begin miscompares++; $display("FAIL release_chan got=%0d exp=2", r0_chan); end
    vectors++; if (r0_ovld !== 1'b1) begin miscompares++; $display("FAIL release_ovld got=%0b exp=1", r0_ovld); end
  endtask

  task automatic test_bad_sel;
    b_sel = 2'd1; b_valid = 3'b010; b_data = 24'h005C00; b_ordy = 1'b1;
    step;
    b_sel = 2'd3; b_valid = 3'b111;
    @(negedge clk);
    vectors++; if (s0_irdy !== 3'b000) begin miscompares++; $display("FAIL badsel_irdy got=%b exp=000", s0_irdy); end
    vectors++; if (s0_ovld !== 1'b1) begin miscompares++; $display("FAIL badsel_loaded_ovld got=%0b exp=1", s0_ovld); end
    vectors++; if (s0_data !== 8'h5C) begin miscompares++; $display("FAIL badsel_loaded_data got=%h exp=5c", s0_data); end
    step;
    @(negedge clk);
    vectors++; if (s0_ovld !== 1'b0) begin miscompares++; $display("FAIL badsel_drain_ovld got=%0b exp=0", s0_ovld); end
    vectors++; if (s0_data !== 8'h5C) begin miscompares++; $display("FAIL badsel_hold_data got=%h exp=5c", s0_data); end
    vectors++; if (s0_chan !== 2'd1) begin miscompares++; $display("FAIL badsel_hold_chan got=%0d exp=1", s0_chan); end
    vectors++; if (s0_irdy !== 3'b000) begin miscompares++; $display("FAIL badsel_drain_irdy got=%b exp=000", s0_irdy); end
    step;
    b_valid = '0; b_ordy = 1'b0;
  endtask

  task automatic test_rr_seq;
    a_valid = 4'hF; a_data = 16'h4321; a_ordy = 1'b1;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (r1_irdy !== 4'(1 << (i % 4))) begin miscompares++; $display("FAIL rr_seq_irdy[%0d] got=%b exp=%b", i, r1_irdy, 4'(1 << (i % 4))); end
      step;
      vectors++; if (r1_ovld !== 1'b1) begin miscompares++; $display("FAIL rr_seq_ovld[%0d] got=%0b exp=1", i, r1_ovld); end
      vectors++; if (r1_chan !== 2'(i % 4)) begin miscompares++; $display("FAIL rr_seq_chan[%0d] got=%0d exp=%0d", i, r1_chan, i % 4); end
      vectors++; if (r1_data !== 4'(i % 4 + 1)) begin miscompares++; $display("FAIL rr_seq_data[%0d] got=%h exp=%0d", i, r1_data, i % 4 + 1); end
    end
  endtask

  task automatic test_rr_skip;
    int exp_ch[3] = '{3, 1, 3};
    logic [3:0] exp_d;
    a_valid = 4'hF; a_data = 16'h4321; a_ordy = 1'b1;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step;
    step;
    // Channels 0 and 1 have been served, so the pointer now sits on channel 2.
    a_valid = 4'b1010; a_data = 16'hD0B0;
    for (int i = 0; i < 3; i++) begin
      exp_d = (exp_ch[i] == 3) ? 4'hD : 4'hB;
      @(negedge clk);
      vectors++; if (r1_irdy !== 4'(1 << exp_ch[i])) begin miscompares++; $display("FAIL rr_skip_irdy[%0d] got=%b exp=%b", i, r1_irdy, 4'(1 << exp_ch[i])); end
      step;
      vectors++; if (r1_chan !== 2'(exp_ch[i])) begin miscompares++; $display("FAIL rr_skip_chan[%0d] got=%0d exp=%0d", i, r1_chan, exp_ch[i]); end
      vectors++; if (r1_data !== exp_d) begin miscompares++; $display("FAIL rr_skip_data[%0d] got=%h exp=%h", i, r1_data, exp_d); end
    end
  endtask

  // Reference: each output register is a buffer of at most one word. A word
  // departs when it is offered with out_ready high; a new word may enter when
  // the buffer is empty or departing, taken from the channel the rules pick.
  task automatic test_soak;
    bit         full[2];
    logic [7:0] hd[2];
    logic [1:0] hc[2];
    int         ptr[2];
    bit         can_load;
    int         g, c, s;
    logic [2:0] e_irdy, g_irdy;
    logic [7:0] g_d;
    logic [1:0] g_c;
    logic       g_v;
    b_valid = '0; b_ordy = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      full[m] = 1'b0; hd[m] = '0; hc[m] = '0; ptr[m] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      step;
      b_data  = 24'($urandom);
      b_valid = 3'($urandom_range(0, 7));
      b_sel   = 2'($urandom_range(0, 3));
      b_ordy  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        g_v    = (m == 0) ? s0_ovld : s1_ovld;
        g_d    = (m == 0) ? s0_data : s1_data;
        g_c    = (m == 0) ? s0_chan : s1_chan;
        g_irdy = (m == 0) ? s0_irdy : s1_irdy;
        vectors++; if (g_v !== full[m]) begin miscompares++; $display("FAIL soak%0d_ovld cyc=%0d got=%0b exp=%0b", m, cyc, g_v, full[m]); end
        vectors++; if (g_d !== hd[m]) begin miscompares++; $display("FAIL soak%0d_data cyc=%0d got=%h exp=%h", m, cyc, g_d, hd[m]); end
        vectors++; if (g_c !== hc[m]) begin miscompares++; $display("FAIL soak%0d_chan cyc=%0d got=%0d exp=%0d", m, cyc, g_c, hc[m]); end
        g = -1;
        if (m == 0) begin
          s = int'(b_sel);
          if (s < 3 && ((b_valid >> s) & 3'b001) != 3'b000) g = s;
        end else begin
          for (int k = 0; k < 3; k++) begin
            c = (ptr[m] + k) % 3;
            if (g < 0 && ((b_valid >> c) & 3'b001) != 3'b000) g = c;
          end
        end
        can_load = !full[m] || b_ordy;
        e_irdy = (can_load && g >= 0) ? 3'(1 << g) : 3'b000;
        vectors++; if (g_irdy !== e_irdy) begin miscompares++; $display("FAIL soak%0d_irdy cyc=%0d got=%b exp=%b", m, cyc, g_irdy, e_irdy); end
        if (full[m] && b_ordy) full[m] = 1'b0;
        if (can_load && g >= 0) begin
          full[m] = 1'b1;
          hd[m]   = 8'(b_data >> (8 * g));
          hc[m]   = 2'(g);
          ptr[m]  = (g + 1) % 3;
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_stall;
    test_bad_sel;
    test_rr_seq;
    test_rr_skip;
    test_soak;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
